// File: rtl/iir_mac_sched.sv
// Sequencer for a time-shared IIR multiply/accumulate datapath: coefficient file, tap stepping, pacing.
// Optional build macro IIR_FLUSH_ON_CFG_EN: clear the delay lines for 2 cycles after each coefficient write.
module iir_mac_sched #(
    parameter int CW       = 4,
    parameter int NTAPS    = 5,
    parameter int RATE_DIV = 4,
    parameter int TW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [CW-1:0] cfg_data,
    output logic          cfg_ack,
    output logic [2:0]    tap_sel,
    output logic [CW-1:0] coef,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          shift_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          flush
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_SHIFT,
        S_OUT,
        S_FLUSH
    } state_t;

    localparam logic [2:0]    LAST_TAP   = 3'(NTAPS - 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(RATE_DIV - 1);
    localparam logic [CW-1:0] B_RESET    = CW'(1);
    localparam logic [CW-1:0] A_RESET    = ~CW'(1);

    state_t        state;
    state_t        state_next;
    logic [2:0]    tap_next;
    logic [TW-1:0] timer;
    logic [CW-1:0] coef_reg [NTAPS];
    logic          accept;
    logic          cfg_fire;
    logic          cfg_addr_ok;

    // A request still held during its own ack cycle must not be taken a second time.
    assign cfg_fire    = (state == S_IDLE) && cfg_we && !cfg_ack;
    assign cfg_addr_ok = (cfg_addr <= LAST_TAP);
    assign in_ready    = (state == S_IDLE) && (timer == '0) && !cfg_we;
    assign accept      = in_valid && in_ready;
    assign busy        = (state != S_IDLE);
    assign coef        = coef_reg[tap_sel];

`ifdef IIR_FLUSH_ON_CFG_EN
    logic flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt <= 1'b0;
        end else begin
            flush_cnt <= (state == S_FLUSH) ? !flush_cnt : 1'b0;
        end
    end
`endif

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
        state_next = state;
        tap_next   = tap_sel;
        acc_en     = 1'b0;
        acc_clr    = 1'b0;
        shift_en   = 1'b0;
        out_valid  = 1'b0;
        flush      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_MAC;
                end
`ifdef IIR_FLUSH_ON_CFG_EN
                if (cfg_fire && cfg_addr_ok) begin
                    state_next = S_FLUSH;
                end
`endif
            end
            S_MAC: begin
                acc_en  = 1'b1;
                acc_clr = (tap_sel == 3'd0);
                if (tap_sel == LAST_TAP) begin
                    state_next = S_SHIFT;
                    tap_next   = 3'd0;
                end else begin
                    tap_next = tap_sel + 3'd1;
                end
            end
            S_SHIFT: begin
                shift_en   = 1'b1;
                state_next = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
`ifdef IIR_FLUSH_ON_CFG_EN
            S_FLUSH: begin
                flush = 1'b1;
                if (flush_cnt) begin
                    state_next = S_IDLE;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            tap_sel <= 3'd0;
            timer   <= '0;
            cfg_ack <= 1'b0;
        end else begin
            state   <= state_next;
            tap_sel <= tap_next;
            cfg_ack <= cfg_fire;
            if (accept) begin
                timer <= TIMER_LOAD;
            end else if (timer != '0) begin
                timer <= timer - TW'(1);
            end
        end
    end

    // NOTE: the coefficient file is reset because the filter must start from defined default taps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                coef_reg[i] <= (i < 3) ? B_RESET : A_RESET;
            end
        end else if (cfg_fire && cfg_addr_ok) begin
            coef_reg[cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_iir_mac_sched.sv
// Bench for iir_mac_sched: directed scenarios plus random traffic against a transaction-timing model.
module tb_iir_mac_sched;

    localparam int CW       = 4;
    localparam int NTAPS    = 5;
    localparam int RATE_DIV = 4;
    localparam int SLOW_DIV = 12;
`ifdef IIR_FLUSH_ON_CFG_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rst_slow = 1'b0;
    logic          in_valid = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_addr = 3'd0;
    logic [CW-1:0] cfg_data = '0;
    logic          out_ready = 1'b1;
    logic          in_ready, cfg_ack, acc_clr, acc_en, shift_en, out_valid, busy, flush;
    logic [2:0]    tap_sel;
    logic [CW-1:0] coef;
    logic          s_in_ready, s_cfg_ack, s_acc_clr, s_acc_en, s_shift_en, s_out_valid, s_busy, s_flush;
    logic [2:0]    s_tap_sel;
    logic [CW-1:0] s_coef;

    always #5 clk = ~clk;

    iir_mac_sched #(.CW(CW), .NTAPS(NTAPS), .RATE_DIV(RATE_DIV), .TW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
        .tap_sel(tap_sel), .coef(coef), .acc_clr(acc_clr), .acc_en(acc_en),
        .shift_en(shift_en), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .flush(flush)
    );

    // Second instance: rate timer longer than the 8-cycle sample sequence, always fed.
    iir_mac_sched #(.CW(CW), .NTAPS(NTAPS), .RATE_DIV(SLOW_DIV), .TW(8)) dut_slow (
        .clk(clk), .rst(rst_slow), .in_valid(1'b1), .in_ready(s_in_ready),
        .cfg_we(1'b0), .cfg_addr(3'd0), .cfg_data({CW{1'b0}}), .cfg_ack(s_cfg_ack),
        .tap_sel(s_tap_sel), .coef(s_coef), .acc_clr(s_acc_clr), .acc_en(s_acc_en),
        .shift_en(s_shift_en), .out_valid(s_out_valid), .out_ready(1'b1),
        .busy(s_busy), .flush(s_flush)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: a sample accepted in cycle n owns cycles n+1.. ; tap k at n+1+k, shift at n+6,
    // result offered from n+7 until taken. Writes land only while nothing is in flight.
    bit            in_flight;
    int            acc_cyc, last_acc, ack_cyc, flush_until;
    bit            hs_in, hs_out;
    logic [CW-1:0] mcoef [NTAPS];

    task automatic model_reset();
        in_flight   = 1'b0;
        last_acc    = -1000;
        ack_cyc     = -1000;
        flush_until = -1000;
        for (int i = 0; i < NTAPS; i++) mcoef[i] = (i < 3) ? 4'b0001 : 4'b1110;
    endtask

    // Called at a falling edge after inputs for this cycle are set; returns at the next falling edge.
    task automatic step();
        int         off;
        bit         mac, sh, ov, fl, bsy, rdy;
        logic [2:0] tap;
        #1;
        off = in_flight ? (cyc - acc_cyc) : 0;
        mac = in_flight && (off >= 1) && (off <= NTAPS);
        sh  = in_flight && (off == NTAPS + 1);
        ov  = in_flight && (off >= NTAPS + 2);
        fl  = FLUSH_EN && (cyc <= flush_until);
        bsy = in_flight || fl;
        tap = mac ? 3'(off - 1) : 3'd0;
        rdy = !bsy && (cyc - last_acc >= RATE_DIV) && !cfg_we;
        check("busy", busy, bsy);
        check("tap_sel", tap_sel, tap);
        check("coef", coef, mcoef[tap]);
        check("acc_en", acc_en, mac);
        check("acc_clr", acc_clr, mac && (off == 1));
        check("shift_en", shift_en, sh);
        check("out_valid", out_valid, ov);
        check("in_ready", in_ready, rdy);
        check("cfg_ack", cfg_ack, cyc == ack_cyc);
        check("flush", flush, fl);
        hs_in  = rdy && in_valid;
        hs_out = ov && out_ready;
        if (hs_in) begin
            in_flight = 1'b1;
            acc_cyc   = cyc;
            last_acc  = cyc;
        end
        if (hs_out) in_flight = 1'b0;
        if (cfg_we && !bsy && (cyc != ack_cyc)) begin
            if (cfg_addr < NTAPS) begin
                mcoef[cfg_addr] = cfg_data;
                if (FLUSH_EN) flush_until = cyc + 2;
            end
            ack_cyc = cyc + 1;
        end
        @(negedge clk);
        cyc++;
        if (cfg_ack) cfg_we = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send();
        int guard = 0;
        in_valid = 1'b1;
        do begin
            step();
            guard++;
        end while (!hs_in && guard < 40);
        in_valid = 1'b0;
        check("sample_accepted", hs_in, 1'b1);
    endtask

    int scyc = 0;
    int sq[$];
    always @(negedge clk) begin
        scyc++;
        if (s_acc_clr === 1'b1) sq.push_back(scyc);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rst_slow = 1'b1;
        step();

        // Single sample with downstream always ready, default coefficients.
        out_ready = 1'b1;
        send();
        run(8);

        // Downstream stalls for 10 cycles while the result is offered.
        out_ready = 1'b0;
        send();
        run(NTAPS + 1 + 10);
        out_ready = 1'b1;
        run(2);

        // Write a1 while the sample sits at tap 1; it waits for IDLE, next sample uses it.
        send();
        run(1);
        cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 4'b0101;
        run(12);
        send();
        run(8);

        // Write and sample collide in IDLE: write first; unmapped address only acks.
        cfg_we = 1'b1; cfg_addr = 3'd6; cfg_data = 4'b1001;
        send();
        run(8);

        // Write to b0 (flush window when the feature is built in).
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 4'b0011;
        send();
        run(8);

        // Back-to-back samples: spacing 8 with in_valid held.
        in_valid = 1'b1;
        run(26);
        in_valid = 1'b0;
        run(10);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!cfg_we && $urandom_range(0, 11) == 0) begin
                cfg_we   = 1'b1;
                cfg_addr = 3'($urandom_range(0, 7));
                cfg_data = CW'($urandom);
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        run(30);

        // Asynchronous reset in the middle of the tap sweep.
        send();
        run(2);
        #1;
        check("pre_reset_tap_sel", tap_sel, 3'd2);
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_tap_sel", tap_sel, 3'd0);
        check("rst_acc_en", acc_en, 1'b0);
        check("rst_acc_clr", acc_clr, 1'b0);
        check("rst_shift_en", shift_en, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_cfg_ack", cfg_ack, 1'b0);
        check("rst_flush", flush, 1'b0);
        check("rst_coef0", coef, 4'b0001);
        repeat (2) @(negedge clk);
        cyc += 2;
        rst = 1'b1;
        model_reset();
        step();
        send();
        run(8);

        // Slow instance: accepted samples spaced by the rate timer, not the FSM.
        check("slow_samples_seen", sq.size() >= 3, 1'b1);
        for (int i = 1; i < sq.size(); i++) check("slow_spacing", sq[i] - sq[i-1], SLOW_DIV);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
